// File: rtl/rx_bit_timer_ctrl.sv
// Receive bit-timing controller: finds a start bit, then produces mid-bit shift strobes,
// validates the stop bit and issues a one-cycle buffer load or a sticky framing error.
module rx_bit_timer_ctrl #(
  parameter int CLKS_PER_BIT = 10,
  parameter int DATA_BITS    = 8
) (
  input  logic clk,
  input  logic n_rst,
  input  logic serial_in,
  output logic shift_strobe,
  output logic load_buffer,
  output logic framing_error,
  output logic busy
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CPB     = CW'(CLKS_PER_BIT);
  localparam logic [CW-1:0] CPB_M1  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CPB_M2  = CW'(CLKS_PER_BIT - 2);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START_CHK = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    LOAD      = 3'd4
  } state_t;

  state_t          state_r;
  logic            prev_in_r;
  logic            armed_r;
  logic [CW-1:0]   period_r;
  logic [BW-1:0]   bit_r;
  logic            start_s;

  // armed_r demands the line be seen high after reset, so a line held low never starts a frame
  assign start_s = armed_r & prev_in_r & (serial_in == 1'b0);

  // Line history: previous sample and the post-reset idle-high qualifier
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      prev_in_r <= 1'b1;
      armed_r   <= 1'b0;
    end else begin
      prev_in_r <= serial_in;
      if (serial_in == 1'b1) begin
        armed_r <= 1'b1;
      end else begin
        armed_r <= armed_r;
      end
    end
  end

  // Frame sequencer: counters, state and all registered outputs
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_r       <= IDLE;
      period_r      <= '0;
      bit_r         <= '0;
      shift_strobe  <= 1'b0;
      load_buffer   <= 1'b0;
      framing_error <= 1'b0;
      busy          <= 1'b0;
    end else begin
      shift_strobe <= 1'b0;
      load_buffer  <= 1'b0;
      case (state_r)
        IDLE: begin
          period_r <= '0;
          bit_r    <= '0;
          if (start_s) begin
            state_r <= START_CHK;
            busy    <= 1'b1;
          end else begin
            busy    <= 1'b0;
          end
        end
        START_CHK: begin
          if (period_r == HALF_M1) begin
            period_r <= '0;
            bit_r    <= '0;
            if (serial_in == 1'b0) begin
              state_r <= DATA;
            end else begin
              state_r <= IDLE;
              busy    <= 1'b0;
            end
          end else begin
            period_r <= period_r + CW'(1);
          end
        end
        DATA: begin
          // strobe is registered one cycle ahead so it spans the cycle ending at the mid-bit edge
          if (period_r == CPB_M2) begin
            shift_strobe <= 1'b1;
          end else begin
            shift_strobe <= 1'b0;
          end
          if (period_r == CPB_M1) begin
            bit_r <= bit_r + BW'(1);
            if (bit_r == LAST_BIT) begin
              state_r  <= STOP;
              period_r <= '0;
            end else begin
              period_r <= CPB;
            end
          end else if (period_r == CPB) begin
            period_r <= CW'(1);
          end else begin
            period_r <= period_r + CW'(1);
          end
        end
        STOP: begin
          if (period_r == CPB_M1) begin
            period_r <= '0;
            if (serial_in == 1'b1) begin
              framing_error <= 1'b0;
              load_buffer   <= 1'b1;
              state_r       <= LOAD;
            end else begin
              framing_error <= 1'b1;
              state_r       <= IDLE;
              busy          <= 1'b0;
            end
          end else begin
            period_r <= period_r + CW'(1);
          end
        end
        LOAD: begin
          period_r <= '0;
          bit_r    <= '0;
          // a falling edge landing on the load cycle starts the next frame without a gap
          if (start_s) begin
            state_r <= START_CHK;
            busy    <= 1'b1;
          end else begin
            state_r <= IDLE;
            busy    <= 1'b0;
          end
        end
        default: begin
          state_r  <= IDLE;
          period_r <= '0;
          bit_r    <= '0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule
